// File: rtl/spi_burst_pkg.sv
// rtl/spi_burst_pkg.sv - opcodes, state encoding and command length for the SPI burst slave
package spi_burst_pkg;

  localparam logic [1:0] OP_RD   = 2'b00;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_STAT = 2'b10;
  localparam logic [1:0] OP_RSV  = 2'b11;

  localparam int CMD_LEN = 8;

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, TURN, RD, WR, STAT, IGNORE
  } state_t;

endpackage

// File: rtl/spi_bit_shifter.sv
// rtl/spi_bit_shifter.sv - parallel-load / serial-in / serial-out shift register, MSB out first
module spi_bit_shifter #(
  parameter int DW = 20
) (
  input  logic          SCLK,
  input  logic          iRSTn,
  input  logic          clr,
  input  logic          load,
  input  logic          shift,
  input  logic [DW-1:0] din,
  input  logic          sin,
  output logic [DW-1:0] q,
  output logic          sout
);

  always_ff @(posedge SCLK or negedge iRSTn) begin
    if (!iRSTn)     q <= '0;
    else if (clr)   q <= '0;
    else if (load)  q <= din;
    else if (shift) q <= {q[DW-2:0], sin};
  end

  assign sout = q[DW-1];

endmodule

// File: rtl/spi_burst_slave.sv
// rtl/spi_burst_slave.sv - SPI slave bridging command/address/burst frames to a word memory port
module spi_burst_slave
  import spi_burst_pkg::*;
#(
  parameter int DW = 20,
  parameter int AW = 5
) (
  input  logic          SCLK,
  input  logic          iRSTn,
  input  logic          iCLR,
  input  logic          CS,
  input  logic          MOSI,
  output logic          MISO,
  output logic [AW-1:0] oADDR,
  output logic          oRd_EN,
  input  logic [DW-1:0] iDATA,
  output logic [DW-1:0] oDATA,
  output logic          oWr_EN,
  output logic          oRd_DONE,
  output logic          oWr_DONE,
  output logic          oFRAME_DONE
);

  localparam int CW = $clog2(((DW > AW) ? DW : AW) + 1);
  localparam logic [CW-1:0] C_DW   = CW'(DW);
  localparam logic [CW-1:0] C_DW1  = CW'(DW - 1);
  localparam logic [CW-1:0] C_DW2  = CW'(DW - 2);
  localparam logic [CW-1:0] C_AW1  = CW'(AW - 1);
  localparam logic [CW-1:0] C_CMD1 = CW'(CMD_LEN - 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  state_t          state, nxt_state;
  logic [CW-1:0]   bit_cnt, nxt_cnt;
  logic [1:0]      op, nxt_op;
  logic [DW-1:0]   pf, nxt_pf;
  logic            abort, nxt_abort;
  logic [7:0]      frame_cnt, nxt_frame_cnt;
  logic            wrote, nxt_wrote;
  logic            nxt_miso, nxt_rd_en, nxt_wr_en, nxt_rd_done, nxt_wr_done, nxt_frame_done;
  logic [AW-1:0]   nxt_addr;
  logic [DW-1:0]   nxt_data;
  logic            sh_clr, sh_load, sh_shift, sh_sout;
  logic [DW-1:0]   sh_din, sh_q, status_word;

  spi_bit_shifter #(.DW(DW)) u_shifter (
    .SCLK  (SCLK),
    .iRSTn (iRSTn),
    .clr   (sh_clr),
    .load  (sh_load),
    .shift (sh_shift),
    .din   (sh_din),
    .sin   (MOSI),
    .q     (sh_q),
    .sout  (sh_sout)
  );

  always_comb begin
    status_word       = '0;
    status_word[DW-1] = abort;
    status_word[7:0]  = frame_cnt;
  end

  always_comb begin
    nxt_state      = state;
    nxt_cnt        = bit_cnt;
    nxt_op         = op;
    nxt_pf         = pf;
    nxt_abort      = abort;
    nxt_frame_cnt  = frame_cnt;
    nxt_wrote      = wrote;
    nxt_miso       = 1'b0;
    nxt_addr       = oADDR;
    nxt_data       = oDATA;
    nxt_rd_en      = 1'b0;
    nxt_wr_en      = 1'b0;
    nxt_rd_done    = 1'b0;
    nxt_wr_done    = 1'b0;
    nxt_frame_done = 1'b0;
    sh_clr         = 1'b0;
    sh_load        = 1'b0;
    sh_shift       = 1'b0;
    sh_din         = iDATA;

    if (oWr_EN) nxt_addr = oADDR + 1'b1;

    if (iCLR) begin
      nxt_state = IDLE;
      nxt_cnt   = '0;
      nxt_op    = OP_RD;
      nxt_pf    = '0;
      nxt_abort = 1'b0;
      nxt_wrote = 1'b0;
      nxt_addr  = '0;
      nxt_data  = '0;
      sh_clr    = 1'b1;
    end else if (CS && state != IDLE) begin
      nxt_state      = IDLE;
      nxt_cnt        = '0;
      nxt_wrote      = 1'b0;
      nxt_frame_done = 1'b1;
      if (state == WR) begin
        // a fully received word still commits on the deselect edge
        if (bit_cnt == C_DW) begin
          nxt_data    = sh_q;
          nxt_wr_en   = 1'b1;
          nxt_wr_done = 1'b1;
        end else if (bit_cnt != '0) begin
          nxt_abort = 1'b1;
        end
        if (wrote || bit_cnt == C_DW) nxt_frame_cnt = frame_cnt + 8'd1;
      end
      if (state == RD && bit_cnt == C_DW) nxt_rd_done = 1'b1;
    end else if (!CS) begin
      case (state)
        IDLE: begin
          sh_shift  = 1'b1;
          nxt_cnt   = C_ONE;
          nxt_state = CMD;
        end
        CMD: begin
          sh_shift = 1'b1;
          nxt_cnt  = bit_cnt + C_ONE;
          if (bit_cnt == C_CMD1) begin
            nxt_cnt = '0;
            nxt_op  = sh_q[CMD_LEN-2 -: 2];
            case (sh_q[CMD_LEN-2 -: 2])
              OP_RD, OP_WR: nxt_state = ADDR;
              OP_STAT:      nxt_state = TURN;
              OP_RSV: begin
                nxt_state = IGNORE;
                nxt_abort = 1'b1;
              end
            endcase
          end
        end
        ADDR: begin
          sh_shift = 1'b1;
          nxt_cnt  = bit_cnt + C_ONE;
          if (bit_cnt == C_AW1) begin
            nxt_cnt  = '0;
            nxt_addr = {sh_q[AW-2:0], MOSI};
            if (op == OP_WR) begin
              nxt_state = WR;
            end else begin
              nxt_rd_en = 1'b1;
              nxt_state = TURN;
            end
          end
        end
        TURN: begin
          sh_load = 1'b1;
          nxt_cnt = '0;
          if (op == OP_STAT) begin
            sh_din    = status_word;
            nxt_abort = 1'b0;
            nxt_state = STAT;
          end else begin
            nxt_state = RD;
          end
        end
        RD: begin
          nxt_miso = sh_sout;
          sh_shift = 1'b1;
          nxt_cnt  = bit_cnt + C_ONE;
          if (bit_cnt == C_DW2) begin
            nxt_rd_en = 1'b1;
            nxt_addr  = oADDR + 1'b1;
          end
          if (oRd_EN) nxt_pf = iDATA;
          // reload edge drives the prefetched MSB directly so the stream has no gap
          if (bit_cnt == C_DW) begin
            nxt_miso    = pf[DW-1];
            sh_shift    = 1'b0;
            sh_load     = 1'b1;
            sh_din      = {pf[DW-2:0], 1'b0};
            nxt_cnt     = C_ONE;
            nxt_rd_done = 1'b1;
          end
        end
        STAT: begin
          nxt_miso = sh_sout;
          sh_shift = 1'b1;
          nxt_cnt  = bit_cnt + C_ONE;
          if (bit_cnt == C_DW1) nxt_state = IGNORE;
        end
        WR: begin
          sh_shift = 1'b1;
          nxt_cnt  = bit_cnt + C_ONE;
          if (bit_cnt == C_DW) begin
            nxt_data    = sh_q;
            nxt_wr_en   = 1'b1;
            nxt_wr_done = 1'b1;
            nxt_wrote   = 1'b1;
            nxt_cnt     = C_ONE;
          end
        end
        IGNORE: ;
      endcase
    end
  end

  always_ff @(posedge SCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      op          <= OP_RD;
      pf          <= '0;
      abort       <= 1'b0;
      frame_cnt   <= '0;
      wrote       <= 1'b0;
      MISO        <= 1'b0;
      oADDR       <= '0;
      oDATA       <= '0;
      oRd_EN      <= 1'b0;
      oWr_EN      <= 1'b0;
      oRd_DONE    <= 1'b0;
      oWr_DONE    <= 1'b0;
      oFRAME_DONE <= 1'b0;
    end else begin
      state       <= nxt_state;
      bit_cnt     <= nxt_cnt;
      op          <= nxt_op;
      pf          <= nxt_pf;
      abort       <= nxt_abort;
      frame_cnt   <= nxt_frame_cnt;
      wrote       <= nxt_wrote;
      MISO        <= nxt_miso;
      oADDR       <= nxt_addr;
      oDATA       <= nxt_data;
      oRd_EN      <= nxt_rd_en;
      oWr_EN      <= nxt_wr_en;
      oRd_DONE    <= nxt_rd_done;
      oWr_DONE    <= nxt_wr_done;
      oFRAME_DONE <= nxt_frame_done;
    end
  end

endmodule
